// File: rtl/ysyx_icache.sv
// Direct-mapped instruction cache, 2^SET_BITS lines of 2^WORD_BITS words, single AR/R refill port.
// Latency: hit responds two cycles after acceptance; a miss adds one AR/R round trip per line word.
// Backpressure: one request in flight; req_ready only in IDLE, response held until rsp_ready.
module ysyx_icache #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int SET_BITS  = 4,
  parameter int WORD_BITS = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_inst,
  output logic [ADDR_W-1:0] rsp_pc,
  input  logic              flush,
  output logic [ADDR_W-1:0] mem_araddr,
  output logic              mem_arvalid,
  input  logic              mem_arready,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rvalid,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt
);

  localparam int SETS   = 1 << SET_BITS;
  localparam int WORDS  = 1 << WORD_BITS;
  localparam int IDX_LO = WORD_BITS + 2;
  localparam int TAG_LO = SET_BITS + WORD_BITS + 2;
  localparam int TAG_W  = ADDR_W - TAG_LO;
  localparam logic [WORD_BITS-1:0] LAST = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_MISS_AR,
    S_MISS_R,
    S_RESP
  } state_e;

  state_e                         state_q;
  logic [ADDR_W-1:0]              addr_q;
  logic [SETS-1:0]                valid_q;
  logic [TAG_W-1:0]               tag_q  [SETS];
  logic [DATA_W-1:0]              data_q [SETS*WORDS];
  logic [WORD_BITS-1:0]           cnt_q;
  logic                           pend_q;
  logic [31:0]                    hit_cnt_q;
  logic [31:0]                    miss_cnt_q;
  logic                           req_ready_q;
  logic                           rsp_valid_q;
  logic                           mem_arvalid_q;
  // LOOKUP spans two cycles: phase 0 reads the tag/valid arrays into
  // registers (SRAM-style), phase 1 compares against the request tag.
  logic                           lk_ph_q;
  logic                           lk_vld_q;
  logic [TAG_W-1:0]               lk_tag_q;

  logic [TAG_W-1:0]               a_tag;
  logic [SET_BITS-1:0]            a_idx;
  logic [WORD_BITS-1:0]           a_off;

  assign a_tag = addr_q[ADDR_W-1:TAG_LO];
  assign a_idx = addr_q[TAG_LO-1:IDX_LO];
  assign a_off = addr_q[IDX_LO-1:2];

  assign req_ready   = req_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign mem_arvalid = mem_arvalid_q;
  assign rsp_pc      = addr_q;
  assign rsp_inst    = data_q[{a_idx, a_off}];
  assign mem_araddr  = {a_tag, a_idx, cnt_q, 2'b00};
  assign hit_cnt     = hit_cnt_q;
  assign miss_cnt    = miss_cnt_q;

  // Control FSM: state, valid bits, refill counter, flush-pending, perf counters, handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      valid_q       <= '0;
      cnt_q         <= '0;
      pend_q        <= 1'b0;
      hit_cnt_q     <= '0;
      miss_cnt_q    <= '0;
      req_ready_q   <= 1'b1;
      rsp_valid_q   <= 1'b0;
      mem_arvalid_q <= 1'b0;
      lk_ph_q       <= 1'b0;
      lk_vld_q      <= 1'b0;
    end else begin
      if (flush) begin
        valid_q <= '0;
      end
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            addr_q      <= req_addr;
            lk_ph_q     <= 1'b0;
            req_ready_q <= 1'b0;
            state_q     <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (!lk_ph_q) begin
            lk_ph_q  <= 1'b1;
            // A flush in this cycle clears the array, so the line must read as invalid.
            lk_vld_q <= valid_q[a_idx] & ~flush;
            lk_tag_q <= tag_q[a_idx];
          end else begin
            lk_ph_q <= 1'b0;
            if (lk_vld_q && (lk_tag_q == a_tag) && !flush) begin
              hit_cnt_q   <= hit_cnt_q + 32'd1;
              rsp_valid_q <= 1'b1;
              state_q     <= S_RESP;
            end else begin
              miss_cnt_q    <= miss_cnt_q + 32'd1;
              cnt_q         <= '0;
              mem_arvalid_q <= 1'b1;
              state_q       <= S_MISS_AR;
            end
          end
        end
        S_MISS_AR: begin
          if (flush) begin
            pend_q <= 1'b1;
          end
          if (mem_arready) begin
            mem_arvalid_q <= 1'b0;
            state_q       <= S_MISS_R;
          end
        end
        S_MISS_R: begin
          if (flush) begin
            pend_q <= 1'b1;
          end
          if (mem_rvalid) begin
            if (cnt_q == LAST) begin
              // A flush seen anywhere in this refill leaves the line invalid;
              // the requester still gets the freshly fetched word.
              if (!pend_q && !flush) begin
                valid_q[a_idx] <= 1'b1;
              end
              pend_q      <= 1'b0;
              rsp_valid_q <= 1'b1;
              state_q     <= S_RESP;
            end else begin
              cnt_q         <= cnt_q + WORD_BITS'(1);
              mem_arvalid_q <= 1'b1;
              state_q       <= S_MISS_AR;
            end
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          rsp_valid_q   <= 1'b0;
          mem_arvalid_q <= 1'b0;
          req_ready_q   <= 1'b1;
          state_q       <= S_IDLE;
        end
      endcase
    end
  end

  // Line storage: refill beats land in ascending word order, tag written with the last beat.
  always_ff @(posedge clk) begin
    if (!rst && (state_q == S_MISS_R) && mem_rvalid) begin
      data_q[{a_idx, cnt_q}] <= mem_rdata;
      if (cnt_q == LAST) begin
        tag_q[a_idx] <= a_tag;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_icache.sv
// Randomised bench for ysyx_icache against a line-level cache model and a hashed backing memory.
// Latency: hit path expected two cycles after acceptance; misses bounded by a cycle budget.
// Backpressure: memory responder inserts random AR/R delays, consumer holds rsp_ready low at random.
module tb_ysyx_icache;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_inst;
  logic [31:0] rsp_pc;
  wire         flush;
  logic [31:0] mem_araddr;
  logic        mem_arvalid;
  logic        mem_arready = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;

  logic flush_main = 1'b0;
  logic flush_rsp  = 1'b0;
  assign flush = flush_main | flush_rsp;

  ysyx_icache #(.ADDR_W(32), .DATA_W(32), .SET_BITS(4), .WORD_BITS(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_inst(rsp_inst), .rsp_pc(rsp_pc),
    .flush(flush),
    .mem_araddr(mem_araddr), .mem_arvalid(mem_arvalid), .mem_arready(mem_arready),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Backing memory contents: a fixed hash of the word address.
  function automatic logic [31:0] memf(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    return (w * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  // Reference model: which lines are resident, plus expected counters.
  bit   [15:0] mvalid = '0;
  logic [23:0] mtag [16];
  int          mhit  = 0;
  int          mmiss = 0;

  // Memory responder knobs and observations.
  int          ar_dly = -1;
  int          r_dly  = -1;
  logic        flush_req = 1'b0;
  logic [31:0] ar_log [$];
  int          ar_unstable = 0;

  int          ms = 0;
  int          ms_cnt = 0;
  int          rcnt = 0;
  logic [31:0] ms_addr = '0;
  logic        fl_fired = 1'b0;

  // AR/R slave: random arready stall, random R delay, optional flush pulse mid-refill.
  always @(negedge clk) begin
    mem_rvalid  = 1'b0;
    mem_arready = 1'b0;
    flush_rsp   = 1'b0;
    if (!flush_req) fl_fired = 1'b0;
    case (ms)
      0: begin
        if (mem_arvalid) begin
          ms_addr = mem_araddr;
          ms_cnt  = (ar_dly < 0) ? int'($urandom_range(0, 3)) : ar_dly;
          if (ms_cnt == 0) begin
            mem_arready = 1'b1;
            ar_log.push_back(mem_araddr);
            rcnt = (r_dly < 0) ? int'($urandom_range(0, 2)) : r_dly;
            ms = 2;
          end else begin
            ms = 1;
          end
        end
      end
      1: begin
        if (!mem_arvalid || (mem_araddr != ms_addr)) ar_unstable++;
        ms_cnt--;
        if (ms_cnt == 0) begin
          mem_arready = 1'b1;
          ar_log.push_back(ms_addr);
          rcnt = (r_dly < 0) ? int'($urandom_range(0, 2)) : r_dly;
          ms = 2;
        end
      end
      default: begin
        if (flush_req && !fl_fired && (ms_addr[3:2] == 2'd2)) begin
          flush_rsp = 1'b1;
          fl_fired  = 1'b1;
        end
        if (rcnt == 0) begin
          mem_rvalid = 1'b1;
          mem_rdata  = memf(ms_addr);
          ms = 0;
        end else begin
          rcnt--;
        end
      end
    endcase
  end

  // mode 0: plain; 1: flush pulse during refill (only if a miss is expected); 2: flush in LOOKUP.
  task automatic fetch(input logic [31:0] a, input int hold, input int mode);
    logic [3:0]  idx;
    logic [23:0] tg;
    bit          exp_hit;
    int          lat;
    int          base;
    int          arv;
    int          unst0;
    idx = a[7:4];
    tg  = a[31:8];
    if (mode == 2) mvalid = '0;
    exp_hit = mvalid[idx] && (mtag[idx] == tg);
    base  = ar_log.size();
    unst0 = ar_unstable;
    arv   = 0;
    flush_req = (mode == 1) && !exp_hit;
    req_valid = 1'b1;
    req_addr  = a;
    rsp_ready = (hold == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
    check("req_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    req_addr  = $urandom;
    lat = 0;
    if (mode == 2) begin
      flush_main = 1'b1;
      @(negedge clk);
      flush_main = 1'b0;
      lat = 1;
    end
    while (!rsp_valid && lat < 500) begin
      if (mem_arvalid) arv++;
      @(negedge clk);
      lat++;
    end
    check("rsp_valid", 32'(rsp_valid), 32'd1);
    if (exp_hit) begin
      check("hit_latency", 32'(lat), 32'd2);
      check("hit_no_arvalid", 32'(arv), 32'd0);
    end
    check("rsp_inst", rsp_inst, memf(a));
    check("rsp_pc", rsp_pc, a);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", 32'(rsp_valid), 32'd1);
      check("hold_inst", rsp_inst, memf(a));
      check("hold_pc", rsp_pc, a);
      check("hold_req_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rsp_consumed", 32'(rsp_valid), 32'd0);
    check("back_idle", 32'(req_ready), 32'd1);
    if (exp_hit) begin
      mhit++;
      check("ar_count_hit", 32'(ar_log.size() - base), 32'd0);
    end else begin
      mmiss++;
      check("ar_count_miss", 32'(ar_log.size() - base), 32'd4);
      for (int k = 0; k < 4; k++) begin
        if (base + k < ar_log.size())
          check("ar_addr", ar_log[base + k], {a[31:4], 4'h0} + 32'(4 * k));
      end
      if (mode == 1) mvalid = '0;
      else begin
        mvalid[idx] = 1'b1;
        mtag[idx]   = tg;
      end
    end
    check("araddr_stable", 32'(ar_unstable - unst0), 32'd0);
    check("hit_cnt", hit_cnt, 32'(mhit));
    check("miss_cnt", miss_cnt, 32'(mmiss));
    flush_req = 1'b0;
  endtask

  task automatic flush_idle();
    flush_main = 1'b1;
    @(negedge clk);
    flush_main = 1'b0;
    mvalid = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1);
  end

  initial begin
    logic [31:0] a;
    int          n;
    repeat (3) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_arvalid", 32'(mem_arvalid), 32'd0);
    check("rst_hit_cnt", hit_cnt, 32'd0);
    check("rst_miss_cnt", miss_cnt, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Cold miss, then a hit in the same line.
    fetch(32'h8000_0004, 0, 0);
    check("cold_miss_cnt", miss_cnt, 32'd1);
    fetch(32'h8000_000C, 0, 0);
    check("first_hit_cnt", hit_cnt, 32'd1);
    // Conflict in set 0.
    fetch(32'h8000_0100, 0, 0);
    fetch(32'h8000_0000, 0, 0);
    check("conflict_miss_cnt", miss_cnt, 32'd3);
    // Flush while idle, then flush mid-refill, then flush during LOOKUP.
    flush_idle();
    fetch(32'h8000_0008, 1, 0);
    fetch(32'h8000_0040, 0, 1);
    fetch(32'h8000_0040, 0, 0);
    fetch(32'h8000_0044, 0, 2);
    // Long arready stall and held response.
    ar_dly = 5;
    fetch(32'h8000_0084, 3, 0);
    ar_dly = -1;

    for (int i = 0; i < 80; i++) begin
      a = {24'h80_0000 + 24'($urandom_range(0, 2)), 8'($urandom)};
      n = int'($urandom_range(0, 9));
      if (n == 0) flush_idle();
      fetch(a, int'($urandom_range(0, 2)), (n == 1) ? 1 : ((n == 2) ? 2 : 0));
    end

    // Reset in the middle of a refill; the late R beat must be ignored.
    flush_idle();
    fetch(32'h8000_0000, 0, 0);
    ar_dly = 0;
    r_dly  = 4;
    req_valid = 1'b1;
    req_addr  = 32'h8000_0340;
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (!mem_arvalid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("reset_test_arvalid", 32'(mem_arvalid), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_req_ready", 32'(req_ready), 32'd1);
    check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("midrst_arvalid", 32'(mem_arvalid), 32'd0);
    check("midrst_hit_cnt", hit_cnt, 32'd0);
    check("midrst_miss_cnt", miss_cnt, 32'd0);
    repeat (8) @(negedge clk);
    check("late_r_rsp_valid", 32'(rsp_valid), 32'd0);
    check("late_r_req_ready", 32'(req_ready), 32'd1);
    mvalid = '0;
    mhit   = 0;
    mmiss  = 0;
    ar_dly = -1;
    r_dly  = -1;
    fetch(32'h8000_0000, 0, 0);
    check("post_rst_miss_cnt", miss_cnt, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ysyx_icache.md
YSYX_ICACHE -- requirements
Module: ysyx_icache

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, fetch/bus address width.
REQ-002 SHALL have parameter DATA_W, default 32, instruction/bus data width.
REQ-003 SHALL have parameter SET_BITS, default 4, index width (2^SET_BITS sets, direct-mapped).
REQ-004 SHALL have parameter WORD_BITS, default 2, word-offset width (2^WORD_BITS words per line).
REQ-005 SHALL have ports: clk in 1 clock; rst in 1 synchronous active-high reset.
REQ-006 SHALL have ports: req_valid in 1 fetch request; req_ready out 1 request accepted; req_addr in ADDR_W fetch PC.
REQ-007 SHALL have ports: rsp_valid out 1 instruction ready; rsp_ready in 1 consumer accepts; rsp_inst out DATA_W instruction; rsp_pc out ADDR_W PC of rsp_inst.
REQ-008 SHALL have port flush in 1, fence.i invalidate-all pulse.
REQ-009 SHALL have ports: mem_araddr out ADDR_W; mem_arvalid out 1; mem_arready in 1; mem_rdata in DATA_W; mem_rvalid in 1 (always accepted, no rready).
REQ-010 SHALL have ports: hit_cnt out 32; miss_cnt out 32, performance counters.
REQ-011 SHALL use one clock domain, clk; rst is synchronous and active-high.

Function
REQ-012 SHALL split address: offset [WORD_BITS+1:2], index [SET_BITS+WORD_BITS+1:WORD_BITS+2], tag = remaining upper bits; addr[1:0] ignored.
REQ-013 SHALL store per set: valid bit, tag, 2^WORD_BITS data words.
REQ-014 SHALL implement FSM states IDLE, LOOKUP, MISS_AR, MISS_R, RESP.
REQ-015 SHALL drive req_ready=1 only in IDLE; handshake req_valid&req_ready registers req_addr, IDLE->LOOKUP.
REQ-016 LOOKUP: hit = valid[index] & tag match; hit -> RESP, hit_cnt+1; miss -> MISS_AR, word counter=0, miss_cnt+1.
REQ-017 Hit latency SHALL be exactly 2 cycles: accept at edge N, rsp_valid high in cycle after edge N+2.
REQ-018 MISS_AR: mem_arvalid=1, mem_araddr={tag,index,counter,2'b00}, held stable until mem_arready; on arready -> MISS_R.
REQ-019 MISS_R: on mem_rvalid write mem_rdata to word[counter]; counter<last -> counter+1, MISS_AR; counter==last -> write tag, set valid, RESP.
REQ-020 Refill SHALL fetch words in ascending order 0..2^WORD_BITS-1 regardless of requested offset.
REQ-021 RESP: rsp_valid=1, rsp_inst=word[offset] of registered address, rsp_pc=registered address; both stable until rsp_ready; on rsp_ready -> IDLE.
REQ-022 mem_arvalid SHALL be 0 in every state except MISS_AR.
REQ-023 flush SHALL clear all valid bits at the next edge in any state; counters unaffected.
REQ-024 flush during MISS_AR/MISS_R SHALL set a pending bit so the refilled line is NOT marked valid; the response is still delivered with refilled data; pending bit clears on entering RESP.
REQ-025 flush in same cycle as LOOKUP SHALL force a miss.
REQ-026 Counters SHALL wrap 0xFFFFFFFF -> 0.
REQ-027 rsp_ready while rsp_valid=0 SHALL have no effect.

Reset
REQ-028 rst in any state SHALL at next edge: state IDLE, all valid bits 0, counter 0, pending 0, hit_cnt=miss_cnt=0.
REQ-029 Outputs after reset: req_ready=1, rsp_valid=0, mem_arvalid=0, rsp_inst/rsp_pc/mem_araddr don't-care; data/tag arrays not reset.
REQ-030 rst mid-refill SHALL abandon the refill; a late mem_rvalid in IDLE SHALL be ignored.

Verification (SET_BITS=4, WORD_BITS=2)
REQ-031 Cold miss req 0x80000004 -> AR addrs 0x80000000,04,08,0C in order; rsp_inst=word1 returned, rsp_pc=0x80000004, miss_cnt=1.
REQ-032 Then req 0x8000000C -> no mem_arvalid, rsp_valid 2 cycles after accept, rsp_inst=word3, hit_cnt=1.
REQ-033 Conflict: req 0x80000100 (index 0, new tag) misses and refills; then 0x80000000 misses again, miss_cnt=3.
REQ-034 flush pulse, then req 0x80000008 -> miss; flush during MISS_R of refill -> response delivered, repeat same address misses.
REQ-035 rsp_ready low 3 cycles in RESP -> rsp_valid, rsp_inst, rsp_pc stable, req_ready=0; mem_arready delayed 5 cycles -> mem_araddr stable.
REQ-036 rst asserted in MISS_R -> next cycle IDLE, mem_arvalid=0, counters 0, prior line at 0x80000000 misses.
